// File: rtl/prng_range_sampler.sv
// Purpose : map raw PRNG words to unbiased integers in [0, r) (multiply-high + rejection) and stream them out.
// Latency : din sampled at edge n -> dout_valid after edge n+3 (empty FIFO, accepted word); range_load costs W busy cycles.
// Backpressure: valid/ready output; when the FIFO is full and not popping, an accepted sample is dropped and overflow sticks.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   din, din_valid        raw PRNG word and its qualifier (ignored while busy)
//   range_in, range_load  new range r (0 = passthrough); 1-cycle load strobe (also flushes everything)
//   busy                  threshold division in progress
//   dout, dout_valid      output sample / FIFO non-empty
//   dout_ready            consumer accept
//   overflow              sticky sample-dropped flag, cleared by reset or range_load
// Optional: define PRNG_SAMPLER_STATS_EN to add accept_count / reject_count outputs.

module prng_range_sampler #(
  parameter int W     = 32,
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] din,
  input  logic         din_valid,
  input  logic [W-1:0] range_in,
  input  logic         range_load,
  output logic         busy,
  output logic [W-1:0] dout,
  output logic         dout_valid,
  input  logic         dout_ready,
  output logic         overflow
`ifdef PRNG_SAMPLER_STATS_EN
  ,
  output logic [31:0]  accept_count,
  output logic [31:0]  reject_count
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(W - 1);
  localparam logic [AW:0]   FULL_CNT  = (AW + 1)'(DEPTH);

  typedef enum logic {RUN, CALC} state_t;

  state_t state, state_nxt;

  // range / threshold
  logic [W-1:0]  r;
  logic [W-1:0]  t;
  logic [W-1:0]  div_q;     // dividend (2^W - r), shifted out MSB first
  logic [W-1:0]  rem;       // partial remainder, always < r
  logic [CW-1:0] cnt;
  logic [W:0]    rem_shift;
  logic [W-1:0]  rem_sub;
  logic [W-1:0]  rem_nxt;
  logic          rem_ge;

  // pipeline
  logic [2*W-1:0] prod;
  logic [2*W-1:0] m;
  logic           s1_vld;
  logic           accept;
  logic           s2_vld;
  logic [W-1:0]   s2_dat;

  // FIFO
  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr, rd_ptr;
  logic [AW:0]  mem_cnt, occ;
  logic         full, pop, push, drop, load_out;

  // ------------------------------------------------------------------
  // Control FSM
  // ------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) state <= RUN;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (range_load)
      state_nxt = CALC;
    else if (state == CALC && (r == '0 || cnt == LAST_STEP))
      state_nxt = RUN;
  end

  assign busy = (state == CALC);

  // ------------------------------------------------------------------
  // Threshold t = (2^W - r) mod r by restoring division, one bit per cycle.
  // 2^W - r is the W-bit two's complement of r. rem < r always, so the
  // W-bit subtraction below is exact whenever rem_ge is set.
  // ------------------------------------------------------------------
  assign rem_shift = {rem, div_q[W-1]};
  assign rem_ge    = (rem_shift >= {1'b0, r});
  assign rem_sub   = rem_shift[W-1:0] - r;
  assign rem_nxt   = rem_ge ? rem_sub : rem_shift[W-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      r     <= '0;
      t     <= '0;
      div_q <= '0;
      rem   <= '0;
      cnt   <= '0;
    end else if (range_load) begin
      r     <= range_in;
      t     <= '0;
      div_q <= ~range_in + {{(W-1){1'b0}}, 1'b1};
      rem   <= '0;
      cnt   <= '0;
    end else if (state == CALC && r != '0) begin
      rem   <= rem_nxt;
      div_q <= {div_q[W-2:0], 1'b0};
      cnt   <= cnt + 1'b1;
      if (cnt == LAST_STEP) t <= rem_nxt;
    end
  end

  // ------------------------------------------------------------------
  // Stage 1: m = din * r. For r = 0 the raw word is placed in the high
  // half; with t = 0 stage 2 then accepts it unchanged.
  // ------------------------------------------------------------------
  assign prod = {{W{1'b0}}, din} * {{W{1'b0}}, r};

  always_ff @(posedge clk) begin
    if (reset || range_load) begin
      s1_vld <= 1'b0;
      m      <= '0;
    end else begin
      s1_vld <= (state == RUN) && din_valid;
      if (state == RUN && din_valid)
        m <= (r == '0) ? {din, {W{1'b0}}} : prod;
    end
  end

  // ------------------------------------------------------------------
  // Stage 2: Lemire rejection on the low half.
  // ------------------------------------------------------------------
  assign accept = (m[W-1:0] >= t);

  always_ff @(posedge clk) begin
    if (reset || range_load) begin
      s2_vld <= 1'b0;
      s2_dat <= '0;
    end else begin
      s2_vld <= s1_vld && accept;
      s2_dat <= m[2*W-1:W];
    end
  end

  // ------------------------------------------------------------------
  // FIFO: memory plus a registered head. Occupancy counts both, so the
  // total capacity is exactly DEPTH.
  // ------------------------------------------------------------------
  assign mem_cnt  = wr_ptr - rd_ptr;
  assign occ      = mem_cnt + {{AW{1'b0}}, dout_valid};
  assign full     = (occ == FULL_CNT);
  assign pop      = dout_valid && dout_ready;
  assign push     = s2_vld && (!full || pop);
  assign drop     = s2_vld && full && !pop;
  assign load_out = (mem_cnt != '0) && (!dout_valid || pop);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= s2_dat;
  end

  always_ff @(posedge clk) begin
    if (reset || range_load) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (load_out) begin
        dout       <= mem[rd_ptr[AW-1:0]];
        rd_ptr     <= rd_ptr + 1'b1;
        dout_valid <= 1'b1;
      end else if (pop) begin
        dout_valid <= 1'b0;
      end
      if (drop) overflow <= 1'b1;
    end
  end

`ifdef PRNG_SAMPLER_STATS_EN
  // One count per stage-2 decision made under the current range.
  always_ff @(posedge clk) begin
    if (reset || range_load) begin
      accept_count <= '0;
      reject_count <= '0;
    end else if (s1_vld && state == RUN) begin
      if (accept) accept_count <= accept_count + 32'd1;
      else        reject_count <= reject_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_prng_range_sampler.sv
module tb_prng_range_sampler;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] din;
  logic         din_valid;
  logic [W-1:0] range_in;
  logic         range_load;
  logic         busy;
  logic [W-1:0] dout;
  logic         dout_valid;
  logic         dout_ready;
  logic         overflow;
`ifdef PRNG_SAMPLER_STATS_EN
  logic [31:0]  accept_count;
  logic [31:0]  reject_count;
`endif

  int errors = 0;
  int checks = 0;

  logic [W-1:0] drv[$];
  logic [W-1:0] got[$];
  logic [W-1:0] exp_q[$];

  prng_range_sampler #(.W(W), .DEPTH(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .din        (din),
    .din_valid  (din_valid),
    .range_in   (range_in),
    .range_load (range_load),
    .busy       (busy),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .overflow   (overflow)
`ifdef PRNG_SAMPLER_STATS_EN
    ,
    .accept_count (accept_count),
    .reject_count (reject_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One cycle: drive next queued word, record the word the coming edge pops.
  task automatic step();
    if (drv.size() > 0) begin
      din       = drv.pop_front();
      din_valid = 1'b1;
    end else begin
      din_valid = 1'b0;
    end
    if (dout_valid && dout_ready) got.push_back(dout);
    tick();
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic load(input logic [W-1:0] r, output int busy_cycles);
    range_in   = r;
    range_load = 1'b1;
    din_valid  = 1'b0;
    tick();
    range_load  = 1'b0;
    busy_cycles = 0;
    for (int i = 0; i < 100 && busy; i++) begin
      busy_cycles++;
      tick();
    end
  endtask

  task automatic compare_got(input string tag);
    check($sformatf("%s_count", tag), 64'(got.size()), 64'(exp_q.size()));
    for (int i = 0; i < got.size() && i < exp_q.size(); i++)
      check($sformatf("%s[%0d]", tag, i), 64'(got[i]), 64'(exp_q[i]));
    got.delete();
    exp_q.delete();
  endtask

  initial begin
    int bc;
    int n_exp;
    logic [W-1:0] w;
    logic [63:0]  mm;

    reset      = 1'b1;
    din        = '0;
    din_valid  = 1'b0;
    range_in   = '0;
    range_load = 1'b0;
    dout_ready = 1'b1;
    tick();
    tick();
    check("rst_busy",       64'(busy),       64'd0);
    check("rst_dout_valid", 64'(dout_valid), 64'd0);
    check("rst_overflow",   64'(overflow),   64'd0);
    check("rst_dout",       64'(dout),       64'd0);
    reset = 1'b0;
    tick();

    // r = 6: W busy cycles, t = 4
    load(32'd6, bc);
    check("busy_cycles_r6", 64'(bc), 64'd32);

    // latency: din 3 -> 0, valid only after the third edge
    din = 32'h3; din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    check("lat_n0_valid", 64'(dout_valid), 64'd0);
    tick();
    check("lat_n1_valid", 64'(dout_valid), 64'd0);
    tick();
    check("lat_n2_valid", 64'(dout_valid), 64'd0);
    tick();
    check("lat_n3_valid", 64'(dout_valid), 64'd1);
    check("lat_n3_dout",  64'(dout),       64'd0);
    tick();
    check("lat_popped_valid", 64'(dout_valid), 64'd0);

    // 0 -> reject; FFFFFFFF -> 5; low half 2 (<t) reject; low half 4 (=t) -> 2; 3 -> 0
    drv   = '{32'h0, 32'hFFFF_FFFF, 32'h2AAA_AAAB, 32'h5555_5556, 32'h3};
    run(12);
    exp_q = '{32'd5, 32'd2, 32'd0};
    compare_got("r6_stream");

    // r = 0 passthrough, single busy cycle
    load(32'd0, bc);
    check("busy_cycles_r0", 64'(bc), 64'd1);
    drv = '{32'hDEAD_BEEF, 32'h1234_5678};
    run(8);
    exp_q = '{32'hDEAD_BEEF, 32'h1234_5678};
    compare_got("r0_pass");

    // r = 1: everything maps to 0
    load(32'd1, bc);
    check("busy_cycles_r1", 64'(bc), 64'd32);
    drv = '{32'hFFFF_FFFF, 32'h8000_0000, 32'h1, 32'h7};
    run(10);
    exp_q = '{32'd0, 32'd0, 32'd0, 32'd0};
    compare_got("r1_zero");

    // overflow: 20 words into a 16-deep FIFO with ready low
    load(32'd0, bc);
    dout_ready = 1'b0;
    for (int i = 0; i < 20; i++) drv.push_back(32'h100 + 32'(i));
    run(24);
    check("ovf_valid", 64'(dout_valid), 64'd1);
    check("ovf_flag",  64'(overflow),   64'd1);
    check("ovf_head",  64'(dout),       64'h100);
    run(3);
    check("ovf_head_hold", 64'(dout), 64'h100);
    dout_ready = 1'b1;
    run(20);
    for (int i = 0; i < 16; i++) exp_q.push_back(32'h100 + 32'(i));
    compare_got("ovf_drain");
    drv = '{32'hAAA, 32'hBBB};
    run(6);
    exp_q = '{32'hAAA, 32'hBBB};
    compare_got("ovf_resume");
    check("ovf_sticky", 64'(overflow), 64'd1);

    // range_load mid-stream with 5 words held
    dout_ready = 1'b0;
    for (int i = 0; i < 5; i++) drv.push_back(32'h200 + 32'(i));
    run(8);
    check("flush_pre_valid", 64'(dout_valid), 64'd1);
    range_in = 32'd7; range_load = 1'b1; din = 32'h300; din_valid = 1'b1;
    tick();
    range_load = 1'b0;
    dout_ready = 1'b1;
    check("flush_valid",    64'(dout_valid), 64'd0);
    check("flush_overflow", 64'(overflow),   64'd0);
    check("flush_busy",     64'(busy),       64'd1);
    for (int i = 0; i < 100 && busy; i++) begin
      if (dout_valid && dout_ready) got.push_back(dout);
      tick();
    end
    check("flush_busy_done", 64'(busy), 64'd0);
    din_valid = 1'b0;
    run(4);
    check("flush_no_old_words", 64'(got.size()), 64'd0);
    got.delete();
    // r = 7, t = 4: FFFFFFFF -> 6, 80000000 -> 3, 0 rejected
    drv = '{32'hFFFF_FFFF, 32'h8000_0000, 32'h0};
    run(8);
    exp_q = '{32'd6, 32'd3};
    compare_got("r7_stream");

    // reset in the middle of a division
    range_in = 32'd6; range_load = 1'b1;
    tick();
    range_load = 1'b0;
    repeat (5) tick();
    check("midcalc_busy", 64'(busy), 64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midcalc_rst_busy",  64'(busy),       64'd0);
    check("midcalc_rst_valid", 64'(dout_valid), 64'd0);
    drv = '{32'hCAFE_F00D};
    run(6);
    exp_q = '{32'hCAFE_F00D};
    compare_got("post_reset_r0");

    // r = 10 (t = 6) against a reference multiply-high model
    load(32'd10, bc);
    check("busy_cycles_r10", 64'(bc), 64'd32);
    for (int i = 0; i < 600; i++) begin
      w  = $urandom();
      drv.push_back(w);
      mm = {32'd0, w} * 64'd10;
      if (mm[31:0] >= 32'd6) exp_q.push_back(mm[63:32]);
    end
    run(610);
    bc = 0;
    foreach (got[i]) if (got[i] >= 32'd10) bc++;
    check("r10_out_of_range", 64'(bc), 64'd0);
    n_exp = exp_q.size();
`ifdef PRNG_SAMPLER_STATS_EN
    check("stats_total",  64'(accept_count + reject_count), 64'd600);
    check("stats_accept", 64'(accept_count),                64'(n_exp));
`endif
    compare_got("r10_model");
    check("r10_overflow", 64'(overflow), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
